// File: rtl/map_cr_pkg.sv
// map_cr_pkg: shared op codes and FSM state encoding for the MAP PC / return-stack control
package map_cr_pkg;
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;
endpackage

// File: rtl/map_ret_stack.sv
// map_ret_stack: DEPTH x ADDR_W return-address register file with push/pop, top and count
// Ports: clk, rst (async, active-high), push, pop, din (pushed address),
//        top (entry below count), count (0..DEPTH), full, empty.
// Entry storage is not reset; only the count is.
module map_ret_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            din,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   below;
    assign below = count - 1'b1;
    assign top   = mem[below[IDX_W-1:0]];
    assign full  = count == SP_W'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk)
        if (push && !full) mem[count[IDX_W-1:0]] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (push && !full) count <= count + 1'b1;
        else if (pop && !empty) count <= count - 1'b1;
endmodule

// File: rtl/map_pc_stack_ctrl.sv
// map_pc_stack_ctrl: program counter with INC/JUMP/CALL/RET through a hardware return stack
// Ports: CLK, RST (async, active-high), iEN (op qualifier), iOP (op code), iADDR (target),
//        oADDR (PC), oSP (stack count), oFULL, oEMPTY, oERR (sticky stack fault).
// Build option MAP_STACK_TRAP_EN: a stack fault loads TRAP_VECTOR and keeps running
// instead of freezing in the FAULT state.
module map_pc_stack_ctrl
    import map_cr_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'('hF0)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               iEN,
    input  logic [2:0]                         iOP,
    input  logic [ADDR_W-1:0]                  iADDR,
    output logic [ADDR_W-1:0]                  oADDR,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   oSP,
    output logic                               oFULL,
    output logic                               oEMPTY,
    output logic                               oERR
);
`ifdef MAP_STACK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, top;
    logic              err, err_nxt, push, pop, fault;
    assign pc_inc = pc + 1'b1;
    assign oADDR  = pc;
    assign oERR   = err;
    map_ret_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(CLK), .rst(RST), .push(push), .pop(pop), .din(pc_inc),
        .top(top), .count(oSP), .full(oFULL), .empty(oEMPTY)
    );
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state <= ST_RUN;
            pc    <= RESET_VECTOR;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            err   <= err_nxt;
        end
    // A faulting CALL/RET never touches the stack: push/pop stay low on that path.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        err_nxt   = err;
        push      = 1'b0;
        pop       = 1'b0;
        fault     = 1'b0;
        if (state == ST_RUN && iEN)
            case (iOP)
                OP_INC:  pc_nxt = pc_inc;
                OP_JUMP: pc_nxt = iADDR;
                OP_CALL: begin
                    fault  = oFULL;
                    push   = !oFULL;
                    pc_nxt = oFULL ? pc : iADDR;
                end
                OP_RET: begin
                    fault  = oEMPTY;
                    pop    = !oEMPTY;
                    pc_nxt = oEMPTY ? pc : top;
                end
                default: ;
            endcase
        if (fault) begin
            err_nxt   = 1'b1;
            pc_nxt    = TRAP_EN ? TRAP_VECTOR : pc;
            state_nxt = TRAP_EN ? ST_RUN : ST_FAULT;
        end
    end
endmodule

// File: tb/tb_map_pc_stack_ctrl.sv
// tb_map_pc_stack_ctrl: directed and random checks of map_pc_stack_ctrl against a queue-based model
module tb_map_pc_stack_ctrl;
`ifdef MAP_STACK_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic       CLK = 1'b0, RST = 1'b1, iEN = 1'b0;
    logic [2:0] iOP = 3'd0;
    logic [7:0] iADDR = 8'd0;
    logic [7:0] oADDR;
    logic [3:0] oSP;
    logic       oFULL, oEMPTY, oERR;
    int checks = 0, errors = 0;
    int         m_pc;
    logic [7:0] m_stk[$];
    bit         m_err, m_frz;

    map_pc_stack_ctrl dut (
        .CLK(CLK), .RST(RST), .iEN(iEN), .iOP(iOP), .iADDR(iADDR),
        .oADDR(oADDR), .oSP(oSP), .oFULL(oFULL), .oEMPTY(oEMPTY), .oERR(oERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "/addr"},  32'(oADDR),  32'(m_pc));
        chk({tag, "/sp"},    32'(oSP),    32'(m_stk.size()));
        chk({tag, "/full"},  32'(oFULL),  32'(m_stk.size() == 8));
        chk({tag, "/empty"}, 32'(oEMPTY), 32'(m_stk.size() == 0));
        chk({tag, "/err"},   32'(oERR),   32'(m_err));
    endtask

    function automatic void m_reset();
        m_pc = 0;
        m_stk.delete();
        m_err = 0;
        m_frz = 0;
    endfunction

    function automatic void m_fault();
        m_err = 1;
        if (TRAP) m_pc = 8'hF0;
        else m_frz = 1;
    endfunction

    function automatic void m_apply(bit en, logic [2:0] o, logic [7:0] a);
        if (!en || m_frz) return;
        case (o)
            3'd1: m_pc = (m_pc + 1) % 256;
            3'd2: m_pc = a;
            3'd3: if (m_stk.size() == 8) m_fault();
                  else begin m_stk.push_back(8'((m_pc + 1) % 256)); m_pc = a; end
            3'd4: if (m_stk.size() == 0) m_fault();
                  else m_pc = m_stk.pop_back();
            default: ;
        endcase
    endfunction

    task automatic op(bit en, logic [2:0] o, logic [7:0] a, string tag);
        @(negedge CLK);
        iEN = en; iOP = o; iADDR = a;
        m_apply(en, o, a);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        @(negedge CLK);
        RST = 1'b1;
        m_reset();
        #1;
        check_all(tag);
        iEN = 1'b0;
        #1 RST = 1'b0;
    endtask

    initial begin
        logic [2:0] o;
        int         r;
        m_reset();
        repeat (2) @(negedge CLK);
        check_all("por");
        RST = 1'b0;
        // 1: async reset in the middle of a CALL
        op(1, 3'd2, 8'h33, "t1_jump");
        op(1, 3'd3, 8'h50, "t1_call");
        @(negedge CLK);
        iEN = 1'b1; iOP = 3'd3; iADDR = 8'h77;
        #2 RST = 1'b1;
        m_reset();
        #1 check_all("t1_async_rst");
        iEN = 1'b0;
        #1 RST = 1'b0;
        // 2: PC wrap and iEN gating
        op(1, 3'd2, 8'hFE, "t2_jump");
        repeat (3) op(1, 3'd1, 8'h00, "t2_inc");
        op(0, 3'd1, 8'h00, "t2_en0");
        // 3: call / return pair
        op(1, 3'd2, 8'h10, "t3_jump");
        op(1, 3'd3, 8'h40, "t3_call");
        op(1, 3'd4, 8'h00, "t3_ret");
        // 4: overflow
        for (int i = 0; i < 8; i++) op(1, 3'd3, 8'(8'h20 + i * 4), "t4_call");
        op(1, 3'd3, 8'h99, "t4_ovf");
        op(1, 3'd1, 8'h00, "t4_inc_after");
        op(1, 3'd2, 8'h22, "t4_jump_after");
        do_reset("t4_rst");
        // 5: underflow
        op(1, 3'd2, 8'h5A, "t5_jump");
        op(1, 3'd4, 8'h00, "t5_unf");
        op(1, 3'd1, 8'h00, "t5_inc_after");
        do_reset("t5_rst");
        // 6: reserved ops
        op(1, 3'd2, 8'h44, "t6_jump");
        op(1, 3'd3, 8'h60, "t6_call");
        op(1, 3'd5, 8'h11, "t6_op5");
        op(1, 3'd6, 8'h12, "t6_op6");
        op(1, 3'd7, 8'h13, "t6_op7");
        // random traffic, periodic resets to leave FAULT
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
            else begin
                r = $urandom_range(0, 9);
                o = r < 2 ? 3'd1 : r == 2 ? 3'd2 : r < 6 ? 3'd3 : r < 9 ? 3'd4 : 3'($urandom_range(5, 7));
                op($urandom_range(0, 7) != 0, o, 8'($urandom), "rnd");
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
